// File: rtl/sprite_draw_scheduler.sv
// rtl/sprite_draw_scheduler.sv - per-frame erase/redraw arbiter for 5x5 sprites onto one VGA write port
module sprite_draw_scheduler #(
  parameter int         N_SPRITES = 5,
  parameter logic [2:0] BG_COLOUR = 3'b000
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    frame_tick,
  input  logic [8*N_SPRITES-1:0]  x_in,
  input  logic [7*N_SPRITES-1:0]  y_in,
  input  logic [25*N_SPRITES-1:0] shape_in,
  input  logic [3*N_SPRITES-1:0]  colour_in,
  output logic [7:0]              vga_x,
  output logic [6:0]              vga_y,
  output logic [2:0]              vga_colour,
  output logic                    vga_plot,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    overrun
);

  localparam int IW = (N_SPRITES > 1) ? $clog2(N_SPRITES) : 1;

  typedef enum logic [2:0] {IDLE, LATCH, ERASE, DRAW, DONE} state_t;

  state_t  state_q, state_d;
  logic [IW-1:0] i_q, i_d;
  logic [4:0]    p_q, p_d;

  logic [N_SPRITES-1:0][7:0]  new_x_q, new_x_d, old_x_q, old_x_d;
  logic [N_SPRITES-1:0][6:0]  new_y_q, new_y_d, old_y_q, old_y_d;
  logic [N_SPRITES-1:0][24:0] new_shape_q, new_shape_d, old_shape_q, old_shape_d;
  logic [N_SPRITES-1:0][2:0]  new_colour_q, new_colour_d;
  logic [N_SPRITES-1:0]       old_valid_q, old_valid_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      i_q          <= '0;
      p_q          <= '0;
      new_x_q      <= '0;
      new_y_q      <= '0;
      new_shape_q  <= '0;
      new_colour_q <= '0;
      old_x_q      <= '0;
      old_y_q      <= '0;
      old_shape_q  <= '0;
      old_valid_q  <= '0;
    end else begin
      state_q      <= state_d;
      i_q          <= i_d;
      p_q          <= p_d;
      new_x_q      <= new_x_d;
      new_y_q      <= new_y_d;
      new_shape_q  <= new_shape_d;
      new_colour_q <= new_colour_d;
      old_x_q      <= old_x_d;
      old_y_q      <= old_y_d;
      old_shape_q  <= old_shape_d;
      old_valid_q  <= old_valid_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    i_d          = i_q;
    p_d          = p_q;
    new_x_d      = new_x_q;
    new_y_d      = new_y_q;
    new_shape_d  = new_shape_q;
    new_colour_d = new_colour_q;
    old_x_d      = old_x_q;
    old_y_d      = old_y_q;
    old_shape_d  = old_shape_q;
    old_valid_d  = old_valid_q;
    case (state_q)
      IDLE: if (frame_tick) state_d = LATCH;
      LATCH: begin
        // Snapshot once per pass so a sprite moving mid-pass cannot tear.
        for (int k = 0; k < N_SPRITES; k++) begin
          new_x_d[k]      = x_in[8*k +: 8];
          new_y_d[k]      = y_in[7*k +: 7];
          new_shape_d[k]  = shape_in[25*k +: 25];
          new_colour_d[k] = colour_in[3*k +: 3];
        end
        i_d     = '0;
        p_d     = '0;
        state_d = ERASE;
      end
      ERASE: begin
        if (p_q == 5'd24) begin
          p_d     = '0;
          state_d = DRAW;
        end else begin
          p_d = p_q + 5'd1;
        end
      end
      DRAW: begin
        if (p_q == 5'd24) begin
          p_d              = '0;
          old_x_d[i_q]     = new_x_q[i_q];
          old_y_d[i_q]     = new_y_q[i_q];
          old_shape_d[i_q] = new_shape_q[i_q];
          old_valid_d[i_q] = 1'b1;
          if (i_q == IW'(N_SPRITES - 1)) begin
            state_d = DONE;
          end else begin
            i_d     = i_q + 1'b1;
            state_d = ERASE;
          end
        end else begin
          p_d = p_q + 5'd1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  logic [4:0]  row, col;
  logic [7:0]  cur_x;
  logic [6:0]  cur_y;
  logic [24:0] cur_shape;
  logic [8:0]  x_sum;
  logic [7:0]  y_sum;
  logic        in_bounds;
  logic        shape_bit;

  always_comb begin
    row        = p_q / 5'd5;
    col        = p_q % 5'd5;
    cur_x      = (state_q == ERASE) ? old_x_q[i_q] : new_x_q[i_q];
    cur_y      = (state_q == ERASE) ? old_y_q[i_q] : new_y_q[i_q];
    cur_shape  = (state_q == ERASE) ? old_shape_q[i_q] : new_shape_q[i_q];
    // Sums are one bit wider so off-screen pixels are suppressed rather than wrapped.
    x_sum      = {1'b0, cur_x} + {4'b0, col};
    y_sum      = {1'b0, cur_y} + {3'b0, row};
    in_bounds  = (x_sum < 9'd160) && (y_sum < 8'd120);
    shape_bit  = cur_shape[5'd24 - p_q];

    vga_x      = '0;
    vga_y      = '0;
    vga_colour = '0;
    vga_plot   = 1'b0;
    busy       = (state_q != IDLE);
    frame_done = (state_q == DONE);
    overrun    = frame_tick && (state_q != IDLE);
    case (state_q)
      ERASE: begin
        vga_x      = x_sum[7:0];
        vga_y      = y_sum[6:0];
        vga_colour = BG_COLOUR;
        vga_plot   = shape_bit & old_valid_q[i_q] & in_bounds;
      end
      DRAW: begin
        vga_x      = x_sum[7:0];
        vga_y      = y_sum[6:0];
        vga_colour = new_colour_q[i_q];
        vga_plot   = shape_bit & in_bounds;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// tb/tb_sprite_draw_scheduler.sv - randomized bench against a pixel-list model of the scheduler
module tb_sprite_draw_scheduler;

  localparam int NS = 5;

  logic          clk = 1'b0;
  logic          reset;
  logic          frame_tick;
  logic [8*NS-1:0]  x_in;
  logic [7*NS-1:0]  y_in;
  logic [25*NS-1:0] shape_in;
  logic [3*NS-1:0]  colour_in;
  logic [7:0]    vga_x;
  logic [6:0]    vga_y;
  logic [2:0]    vga_colour;
  logic          vga_plot;
  logic          busy;
  logic          frame_done;
  logic          overrun;

  always #5 clk = ~clk;

  sprite_draw_scheduler #(.N_SPRITES(NS), .BG_COLOUR(3'b000)) dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick),
    .x_in(x_in), .y_in(y_in), .shape_in(shape_in), .colour_in(colour_in),
    .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
    .busy(busy), .frame_done(frame_done), .overrun(overrun)
  );

  int total = 0;
  int bad   = 0;

  int          mo_x[NS], mo_y[NS], mn_x[NS], mn_y[NS], mn_c[NS];
  logic [24:0] mo_sh[NS], mn_sh[NS];
  bit          mo_v[NS];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_sprite(input int k, input logic [7:0] x, input logic [6:0] y,
                            input logic [24:0] sh, input logic [2:0] c);
    x_in[8*k +: 8]       = x;
    y_in[7*k +: 7]       = y;
    shape_in[25*k +: 25] = sh;
    colour_in[3*k +: 3]  = c;
  endtask

  task automatic randomize_inputs();
    for (int k = 0; k < NS; k++) begin
      logic [7:0] x;
      logic [6:0] y;
      x = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(150, 255)) : 8'($urandom_range(0, 159));
      y = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(110, 127)) : 7'($urandom_range(0, 119));
      set_sprite(k, x, y, 25'($urandom), 3'($urandom_range(0, 7)));
    end
  endtask

  // ovr_at/rst_at are cycle offsets from the tick cycle t; -1 disables them.
  task automatic run_pass(input int ovr_at, input bit ovr_done, input int rst_at, input bit scramble);
    for (int k = 0; k < NS; k++) begin
      mn_x[k]  = int'(x_in[8*k +: 8]);
      mn_y[k]  = int'(y_in[7*k +: 7]);
      mn_sh[k] = shape_in[25*k +: 25];
      mn_c[k]  = int'(colour_in[3*k +: 3]);
    end
    frame_tick = 1'b1;
    #1;
    check_eq("overrun_idle", overrun, 0);
    step();
    frame_tick = 1'b0;
    #1;
    check_eq("latch_busy", busy, 1);
    check_eq("latch_plot", vga_plot, 0);
    for (int c = 0; c < 50 * NS; c++) begin
      int s, q, p, row, col, bx, by, xs, ys;
      bit er, pl;
      logic [24:0] sh;
      step();
      frame_tick = 1'b0;
      if (c + 2 == rst_at) begin
        reset = 1'b1;
        step();
        reset = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_plot", vga_plot, 0);
        check_eq("rst_done", frame_done, 0);
        for (int k = 0; k < NS; k++) mo_v[k] = 1'b0;
        return;
      end
      if (c + 2 == ovr_at) frame_tick = 1'b1;
      if (scramble && c == 100) randomize_inputs();
      #1;
      s   = c / 50;
      q   = c % 50;
      er  = (q < 25);
      p   = q % 25;
      row = p / 5;
      col = p % 5;
      bx  = er ? mo_x[s] : mn_x[s];
      by  = er ? mo_y[s] : mn_y[s];
      sh  = er ? mo_sh[s] : mn_sh[s];
      xs  = bx + col;
      ys  = by + row;
      pl  = sh[24 - p] && (xs < 160) && (ys < 120) && (er ? mo_v[s] : 1'b1);
      check_eq($sformatf("busy c%0d", c), busy, 1);
      check_eq($sformatf("plot c%0d s%0d p%0d", c, s, p), vga_plot, pl);
      check_eq($sformatf("colour c%0d", c), vga_colour, er ? 0 : mn_c[s]);
      if (pl) begin
        check_eq($sformatf("x c%0d", c), vga_x, xs & 255);
        check_eq($sformatf("y c%0d", c), vga_y, ys & 127);
      end
      if (c + 2 == ovr_at) check_eq("overrun_mid", overrun, 1);
    end
    step();
    frame_tick = ovr_done;
    #1;
    check_eq("done_pulse", frame_done, 1);
    check_eq("done_busy", busy, 1);
    check_eq("done_plot", vga_plot, 0);
    if (ovr_done) check_eq("overrun_done", overrun, 1);
    step();
    frame_tick = 1'b0;
    #1;
    check_eq("end_busy", busy, 0);
    check_eq("end_done", frame_done, 0);
    check_eq("end_plot", vga_plot, 0);
    for (int k = 0; k < NS; k++) begin
      mo_x[k]  = mn_x[k];
      mo_y[k]  = mn_y[k];
      mo_sh[k] = mn_sh[k];
      mo_v[k]  = 1'b1;
    end
  endtask

  initial begin
    reset      = 1'b1;
    frame_tick = 1'b0;
    x_in       = '0;
    y_in       = '0;
    shape_in   = '0;
    colour_in  = '0;
    for (int k = 0; k < NS; k++) begin
      mo_v[k] = 1'b0; mo_x[k] = 0; mo_y[k] = 0; mo_sh[k] = '0;
    end
    step();
    step();
    check_eq("rst_vga_x", vga_x, 0);
    check_eq("rst_vga_y", vga_y, 0);
    check_eq("rst_colour", vga_colour, 0);
    check_eq("rst_plot", vga_plot, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_overrun", overrun, 0);
    reset = 1'b0;
    step();

    randomize_inputs();
    set_sprite(0, 8'd10, 7'd20, {25{1'b1}}, 3'b100);
    run_pass(-1, 1'b0, -1, 1'b0);
    step();

    set_sprite(0, 8'd11, 7'd20, {25{1'b1}}, 3'b100);
    run_pass(-1, 1'b0, -1, 1'b0);
    step();

    set_sprite(1, 8'd0, 7'd0, 25'b1111110101101011111110101, 3'b010);
    set_sprite(2, 8'd158, 7'd118, {25{1'b1}}, 3'b111);
    run_pass(100, 1'b1, -1, 1'b0);
    for (int n = 0; n < 3; n++) begin
      step();
      check_eq($sformatf("no_second_pass %0d", n), busy, 0);
    end

    randomize_inputs();
    run_pass(-1, 1'b0, 60, 1'b0);
    step();
    run_pass(-1, 1'b0, -1, 1'b1);
    step();

    for (int n = 0; n < 4; n++) begin
      randomize_inputs();
      run_pass(-1, 1'b0, -1, 1'b1);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sprite_draw_scheduler.md
# sprite_draw_scheduler

Time-multiplexes the single VGA adapter write port between all 5×5 sprites (Pac-Man plus ghosts). On each frame tick it snapshots every sprite's position, shape and colour, then for each sprite in fixed index order erases the previous footprint with the background colour and draws the new one. It sits between the sprite controllers (ghost and player movement logic) and the VGA adapter.

## Interface
- N_SPRITES, 5, number of sprites arbitrated; sprite 0 is drawn first.
- BG_COLOUR, 3'b000, colour written during erase.
- clk  in  1  system clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_tick  in  1  single-cycle request to start a redraw pass.
- x_in  in  8*N_SPRITES  sprite i x position in bits [8i+7:8i].
- y_in  in  7*N_SPRITES  sprite i y position in bits [7i+6:7i].
- shape_in  in  25*N_SPRITES  sprite i 5×5 mask in [25i+24:25i]; the MSB is the top-left pixel, in row-major order.
- colour_in  in  3*N_SPRITES  sprite i colour.
- vga_x  out  8  pixel x to the adapter.
- vga_y  out  7  pixel y to the adapter.
- vga_colour  out  3  pixel colour.
- vga_plot  out  1  write enable to the adapter.
- busy  out  1  high whenever state ≠ IDLE.
- frame_done  out  1  one-cycle pulse at the end of a pass.
- overrun  out  1  one-cycle pulse when frame_tick arrives while busy.

## Operation
- FSM states: IDLE, LATCH, ERASE, DRAW, DONE.
- IDLE → LATCH on frame_tick. In LATCH, copy x_in, y_in, shape_in and colour_in into the new_* snapshot registers and set sprite index i=0. Inputs are not sampled again until the next pass, so there is no tearing.
- ERASE: pixel counter p runs 0..24, one pixel per cycle.
  - row = p/5, col = p%5.
  - vga_x = old_x[i]+col, vga_y = old_y[i]+row, vga_colour = BG_COLOUR.
  - vga_plot = old_shape[i][24-p] & old_valid[i] & in_bounds.
  - After p=24, go to DRAW with p=0.
- DRAW: same addressing using new_x[i], new_y[i] and new_shape[i], with vga_colour = new_colour[i].
  - vga_plot = new_shape[i][24-p] & in_bounds.
  - After p=24, copy new_*[i] into old_*[i] and set old_valid[i]=1.
  - If i<N_SPRITES-1, increment i and go to ERASE. Otherwise go to DONE.
- DONE: assert frame_done for one cycle, then go to IDLE.
- Bounds arithmetic:
  - Compute 9-bit x+col and 8-bit y+row.
  - in_bounds = (x+col < 160) && (y+row < 120).
  - Out-of-bounds pixels are suppressed, not wrapped. vga_x and vga_y carry the truncated sum.
- old_valid[] is cleared by reset. After reset the first pass skips plotting during ERASE but still spends 25 cycles there, so pass length is constant.
- frame_tick in any state other than IDLE is dropped and pulses overrun in the same cycle.
- Outputs are Moore functions of the state, i, p and the snapshot/old registers. They are 0 in IDLE, LATCH and DONE.

## Timing
- Reset values: vga_x=0, vga_y=0, vga_colour=0, vga_plot=0, busy=0, frame_done=0, overrun=0. State=IDLE, all old_valid=0.
- Reset asserted mid-pass:
  - The next cycle is IDLE with all outputs 0 and old_valid cleared.
  - The aborted pass leaves no pending state.
- For frame_tick sampled high at cycle t:
  - t+1: LATCH, busy=1.
  - t+2: sprite 0 ERASE p=0.
  - t+2+50i+25+p: sprite i DRAW pixel p.
  - t+2+50·N_SPRITES: DONE, frame_done=1.
  - t+3+50·N_SPRITES: IDLE, busy=0.
- With N_SPRITES=5 a pass is 253 cycles from tick to return to IDLE.
- A frame_tick arriving in the same cycle as DONE is an overrun; it does not start a pass.

## Test plan
- Reset, then frame_tick with sprite 0 at (10,20), shape all-ones, colour 3'b100 → cycles t+2..t+26 have vga_plot=0. Cycles t+27..t+51 plot 25 pixels (10..14, 20..24) in colour 3'b100. frame_done is high at t+252.
- Second pass after moving sprite 0 to (11,20) → erase plots 25 pixels at the old footprint with colour 000, then draw plots at 11..15. All other sprites, unchanged, erase and redraw the same pixels.
- Ghost shape 25'b1111110101101011111110101 at (0,0) → in DRAW, vga_plot pulses only for set bits. p=6 (x=1, y=1) is suppressed; p=5 (x=0, y=1) plots.
- Sprite at (158,118) with an all-ones shape → only x∈{158,159} and y∈{118,119} plot, 4 pixels in total. No pixel with x≥160 or y≥120 is written.
- frame_tick pulsed at t+100 during a pass → overrun=1 at t+100. The pass still ends at t+252 and no second pass starts.
- reset asserted at t+60 → at t+61 busy=0 and vga_plot=0. The next frame_tick performs a pass with all ERASE plots suppressed.
